// File: rtl/dop_pkg.sv
// Shared definitions for the DoP lock monitor.
// Holds the standard DoP marker bytes, the lock state encoding and a helper
// that pulls the marker byte out of a stream word of any supported width.
package dop_pkg;

  localparam logic [7:0] DOP_MARKER_0 = 8'h05;
  localparam logic [7:0] DOP_MARKER_1 = 8'hFA;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } dop_state_t;

  // Marker byte is the top byte of the word. The word is passed zero-extended
  // to 64 bits so one helper serves every DATA_W from 8 to 64.
  function automatic logic [7:0] marker_byte(input logic [63:0] word, input int width);
    return 8'(word >> (width - 8));
  endfunction

endpackage

// File: rtl/dop_frame_counter.sv
// Word / channel position counter for one DoP frame.
// Counts valid words only; word index wraps at WORDS_PER_SAMPLE and carries
// into the channel index, which wraps at CHANNELS. The wrap of both ends the
// frame.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clear        load both indices to zero; if advance is also high the word
//                is counted as position 0 of a fresh frame
//   advance      count one word
//   marker_word  current (registered) word index is 0 -> marker word
//   first_word   current (registered) position is word 0 of channel 0
//   frame_end    this advance completes a frame
module dop_frame_counter #(
  parameter int CHANNELS         = 2,
  parameter int WORDS_PER_SAMPLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic advance,
  output logic marker_word,
  output logic first_word,
  output logic frame_end
);

  localparam int WW = (WORDS_PER_SAMPLE > 1) ? $clog2(WORDS_PER_SAMPLE) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [WW-1:0] WORD_LAST = WW'(WORDS_PER_SAMPLE - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(CHANNELS - 1);

  logic [WW-1:0] word_q;
  logic [CW-1:0] ch_q;
  logic [WW-1:0] word_base;
  logic [CW-1:0] ch_base;
  logic          word_wrap;

  // A clear collapses the position to zero before this cycle's advance.
  assign word_base = clear ? '0 : word_q;
  assign ch_base   = clear ? '0 : ch_q;
  assign word_wrap = (word_base == WORD_LAST);

  assign marker_word = (word_q == '0);
  assign first_word  = (word_q == '0) && (ch_q == '0);
  assign frame_end   = advance && word_wrap && (ch_base == CH_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      ch_q   <= '0;
    end else if (advance) begin
      word_q <= word_wrap ? '0 : word_base + 1'b1;
      if (word_wrap) begin
        ch_q <= (ch_base == CH_LAST) ? '0 : ch_base + 1'b1;
      end else begin
        ch_q <= ch_base;
      end
    end else if (clear) begin
      word_q <= '0;
      ch_q   <= '0;
    end
  end

endmodule

// File: rtl/dop_lock_monitor.sv
// DoP lock monitor: finds alternating DoP marker framing in the interleaved
// PCM word stream, acquires lock after ACQ_COUNT good frames, holds it with a
// flywheel phase and LOSS_COUNT bad-frame hysteresis, and drops it on its own.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   data           stream word, marker in the top byte
//   data_valid     word qualifier
//   resync_n       synchronous active-low forced re-hunt
//   locked         DoP lock status (selects the DSD path)
//   lock_event     one-cycle pulse on the rise of locked
//   unlock_event   one-cycle pulse on the fall of locked
//   marker_phase   expected marker of the current frame while locked, else 0
//   frame_start    pulse after the first word of a frame is taken while locked
//   err_cnt        saturating bad-frame count since the last lock
module dop_lock_monitor
  import dop_pkg::*;
#(
  parameter int         DATA_W           = 16,
  parameter int         CHANNELS         = 2,
  parameter int         WORDS_PER_SAMPLE = 2,
  parameter logic [7:0] MARKER_0         = DOP_MARKER_0,
  parameter logic [7:0] MARKER_1         = DOP_MARKER_1,
  parameter int         ACQ_COUNT        = 16,
  parameter int         LOSS_COUNT       = 4,
  parameter int         CNT_W            = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              data_valid,
  input  logic              resync_n,
  output logic              locked,
  output logic              lock_event,
  output logic              unlock_event,
  output logic              marker_phase,
  output logic              frame_start,
  output logic [7:0]        err_cnt
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  dop_state_t       state_q, state_d;
  logic             phase_q, phase_d;
  logic [CNT_W-1:0] acq_q, acq_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             bad_q, bad_d;
  logic [7:0]       err_q, err_d;
  logic             locked_q, locked_d;
  logic             lock_ev_q, lock_ev_d;
  logic             unlock_ev_q, unlock_ev_d;
  logic             fs_q, fs_d;

  logic [7:0] marker;
  logic       hit_0, hit_1, hit_any;
  logic [7:0] expected;
  logic       mw_mismatch;
  logic       restart;
  logic       cnt_clear, cnt_adv;
  logic       marker_word, first_word, frame_end;
  logic       frame_bad;

  assign marker      = marker_byte(64'(data), DATA_W);
  assign hit_0       = (marker == MARKER_0);
  assign hit_1       = (marker == MARKER_1);
  assign hit_any     = hit_0 || hit_1;
  assign expected    = phase_q ? MARKER_1 : MARKER_0;
  assign mw_mismatch = marker_word && (marker != expected);

  // In HUNT every valid word is a candidate; in ACQUIRE a mismatching marker
  // word throws away the partial frame and becomes the candidate itself.
  assign restart = (state_q == HUNT) || ((state_q == ACQUIRE) && mw_mismatch);

  // Counter controls are derived outside the FSM process so that frame_end,
  // which depends on them, can feed the FSM without a combinational loop.
  assign cnt_clear = !resync_n || (data_valid && restart);
  assign cnt_adv   = resync_n && data_valid &&
                     ((state_q == LOCKED) ||
                      ((state_q == ACQUIRE) && !mw_mismatch) ||
                      hit_any);

  dop_frame_counter #(
    .CHANNELS         (CHANNELS),
    .WORDS_PER_SAMPLE (WORDS_PER_SAMPLE)
  ) u_frame_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (cnt_clear),
    .advance     (cnt_adv),
    .marker_word (marker_word),
    .first_word  (first_word),
    .frame_end   (frame_end)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    acq_d       = acq_q;
    loss_d      = loss_q;
    bad_d       = bad_q;
    err_d       = err_q;
    locked_d    = locked_q;
    lock_ev_d   = 1'b0;
    unlock_ev_d = 1'b0;
    fs_d        = 1'b0;
    frame_bad   = 1'b0;

    if (!resync_n) begin
      state_d     = HUNT;
      phase_d     = 1'b0;
      acq_d       = '0;
      loss_d      = '0;
      bad_d       = 1'b0;
      locked_d    = 1'b0;
      unlock_ev_d = locked_q;
    end else if (data_valid) begin
      if (state_q != LOCKED) begin
        if (restart) begin
          acq_d   = '0;
          state_d = HUNT;
          phase_d = 1'b0;
          if (hit_any) begin
            state_d = ACQUIRE;
            phase_d = hit_1;
          end
        end
        // Covers both a running ACQUIRE frame and a candidate word that is
        // itself a whole frame (single-word frames).
        if (frame_end) begin
          phase_d = !phase_d;
          if (acq_d == CNT_W'(ACQ_COUNT - 1)) begin
            state_d   = LOCKED;
            locked_d  = 1'b1;
            lock_ev_d = 1'b1;
            err_d     = 8'd0;
            acq_d     = '0;
            loss_d    = '0;
            bad_d     = 1'b0;
          end else begin
            acq_d = acq_d + 1'b1;
          end
        end
      end else begin
        fs_d      = first_word;
        frame_bad = bad_q || mw_mismatch;
        bad_d     = frame_bad;
        if (frame_end) begin
          bad_d   = 1'b0;
          phase_d = !phase_q;
          if (frame_bad) begin
            err_d = sat_inc8(err_q);
            if (loss_q == CNT_W'(LOSS_COUNT - 1)) begin
              state_d     = HUNT;
              locked_d    = 1'b0;
              unlock_ev_d = 1'b1;
              loss_d      = '0;
              phase_d     = 1'b0;
            end else begin
              loss_d = loss_q + 1'b1;
            end
          end else begin
            loss_d = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      phase_q     <= 1'b0;
      acq_q       <= '0;
      loss_q      <= '0;
      bad_q       <= 1'b0;
      err_q       <= 8'd0;
      locked_q    <= 1'b0;
      lock_ev_q   <= 1'b0;
      unlock_ev_q <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      acq_q       <= acq_d;
      loss_q      <= loss_d;
      bad_q       <= bad_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
      lock_ev_q   <= lock_ev_d;
      unlock_ev_q <= unlock_ev_d;
      fs_q        <= fs_d;
    end
  end

  assign locked       = locked_q;
  assign lock_event   = lock_ev_q;
  assign unlock_event = unlock_ev_q;
  assign marker_phase = locked_q & phase_q;
  assign frame_start  = fs_q;
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_dop_lock_monitor.sv
// Bench for dop_lock_monitor with default parameters (2 channels, 2 words per
// sample, 16-frame acquire, 4-frame loss). Each driven word pushes its
// expected outputs; a monitor pops and compares them half a clock after the
// edge that consumed the word.
module tb_dop_lock_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic        data_valid;
  logic        resync_n;
  logic        locked, lock_event, unlock_event, marker_phase, frame_start;
  logic [7:0]  err_cnt;

  dop_lock_monitor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data         (data),
    .data_valid   (data_valid),
    .resync_n     (resync_n),
    .locked       (locked),
    .lock_event   (lock_event),
    .unlock_event (unlock_event),
    .marker_phase (marker_phase),
    .frame_start  (frame_start),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       lk;
    logic       lev;
    logic       uev;
    logic       ph;
    logic       fs;
    logic [7:0] err;
  } exp_t;

  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  string tag = "init";

  // Bench view of the design: lock status, error count and the phase of the
  // frame the next word belongs to.
  bit         cur_locked;
  bit         cur_ph;
  logic [7:0] cur_err;

  function automatic exp_t mk(input bit lk, input bit lev, input bit uev,
                              input bit ph, input bit fs, input logic [7:0] err);
    exp_t e;
    e.lk = lk; e.lev = lev; e.uev = uev; e.ph = ph; e.fs = fs; e.err = err;
    return e;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e, a;
      e = q.pop_front();
      a = mk(locked, lock_event, unlock_event, marker_phase, frame_start, err_cnt);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got lk=%b lev=%b uev=%b ph=%b fs=%b err=%0d, expected lk=%b lev=%b uev=%b ph=%b fs=%b err=%0d",
                 tag, a.lk, a.lev, a.uev, a.ph, a.fs, a.err,
                 e.lk, e.lev, e.uev, e.ph, e.fs, e.err);
      end
    end
  end

  task automatic drive(input logic v, input logic [15:0] w, input logic rs, input exp_t e);
    data_valid = v;
    data       = w;
    resync_n   = rs;
    @(posedge clk);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 16'($urandom), 1'b1,
            mk(cur_locked, 1'b0, 1'b0, cur_locked & cur_ph, 1'b0, cur_err));
  endtask

  function automatic logic [15:0] mword(input bit ph);
    logic [15:0] w;
    w = 16'($urandom);
    w[15:8] = ph ? 8'hFA : 8'h05;
    return w;
  endfunction

  // One frame of four words; 'corrupt' flips the channel-1 marker so the
  // frame is bad without disturbing the channel-0 alignment.
  task automatic send_frame(input bit ph, input bit corrupt, input int gapmax,
                            input bit lk_after, input bit lev, input bit uev,
                            input logic [7:0] err_after);
    bit         lk0;
    logic [7:0] e0;
    lk0    = cur_locked;
    e0     = cur_err;
    cur_ph = ph;
    for (int p = 0; p < 4; p++) begin
      logic [15:0] w;
      if (gapmax > 0) idle(int'($urandom_range(gapmax, 0)));
      w = 16'($urandom);
      if (p == 0) w = mword(ph);
      if (p == 2) w = mword(ph ^ corrupt);
      if (p < 3)
        drive(1'b1, w, 1'b1, mk(lk0, 1'b0, 1'b0, lk0 & ph, lk0 && (p == 0), e0));
      else
        drive(1'b1, w, 1'b1, mk(lk_after, lev, uev, lk_after & ~ph, 1'b0, err_after));
    end
    cur_locked = lk_after;
    cur_err    = err_after;
    cur_ph     = ~ph;
  endtask

  task automatic acquire(input bit ph0, input int gapmax);
    for (int i = 0; i < 16; i++)
      send_frame((i % 2 == 1) ? ~ph0 : ph0, 1'b0, gapmax, i == 15, i == 15, 1'b0,
                 (i == 15) ? 8'd0 : cur_err);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    data_valid = 1'b0;
    resync_n   = 1'b1;
    data       = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    cur_locked = 1'b0;
    cur_err    = 8'd0;
    cur_ph     = 1'b0;
  endtask

  task automatic test_reset();
    tag        = "reset";
    rst_n      = 1'b0;
    data_valid = 1'b1;
    resync_n   = 1'b1;
    data       = 16'h05A5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({locked, lock_event, unlock_event, marker_phase, frame_start, err_cnt} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {locked, lock_event, unlock_event, marker_phase, frame_start, err_cnt});
    end
    do_reset();
  endtask

  task automatic test_clean_lock();
    tag = "clean_lock";
    do_reset();
    acquire(1'b0, 0);
    for (int i = 0; i < 3; i++) send_frame(cur_ph, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_gaps();
    tag = "gaps";
    do_reset();
    acquire(1'b1, 3);
    for (int i = 0; i < 2; i++) send_frame(cur_ph, 1'b0, 3, 1'b1, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_acq_restart();
    tag = "acq_restart";
    do_reset();
    for (int i = 0; i < 10; i++)
      send_frame(i % 2 == 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'd0);
    // Frame 10 should carry 05; sending FA restarts acquisition on that word.
    acquire(1'b1, 0);
  endtask

  task automatic test_loss();
    tag = "loss";
    do_reset();
    acquire(1'b0, 0);
    for (int i = 1; i <= 3; i++) send_frame(cur_ph, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'(i));
    send_frame(cur_ph, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'd3);
    for (int i = 4; i <= 7; i++)
      send_frame(cur_ph, 1'b1, 0, i != 7, 1'b0, i == 7, 8'(i));
    idle(3);
  endtask

  task automatic test_resync();
    tag = "resync";
    do_reset();
    acquire(1'b0, 0);
    send_frame(cur_ph, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'd1);
    send_frame(cur_ph, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'd2);
    send_frame(cur_ph, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'd2);
    drive(1'b1, mword(cur_ph), 1'b1, mk(1'b1, 1'b0, 1'b0, cur_ph, 1'b1, 8'd2));
    drive(1'b1, 16'($urandom), 1'b1, mk(1'b1, 1'b0, 1'b0, cur_ph, 1'b0, 8'd2));
    drive(1'b1, mword(cur_ph), 1'b0, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2));
    cur_locked = 1'b0;
    drive(1'b1, mword(1'b0), 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2));
    idle(2);
    acquire(1'b1, 0);
  endtask

  task automatic test_resync_collision();
    tag = "resync_collision";
    do_reset();
    for (int i = 0; i < 15; i++)
      send_frame(i % 2 == 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'd0);
    drive(1'b1, mword(1'b1), 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    drive(1'b1, 16'($urandom), 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    drive(1'b1, mword(1'b1), 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    drive(1'b1, 16'($urandom), 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    acquire(1'b0, 0);
  endtask

  task automatic test_reset_mid_acquire();
    tag = "reset_mid_acquire";
    do_reset();
    acquire(1'b0, 0);
    for (int i = 1; i <= 4; i++)
      send_frame(cur_ph, 1'b1, 0, i != 4, 1'b0, i == 4, 8'(i));
    for (int i = 0; i < 10; i++)
      send_frame(i % 2 == 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'd4);
    drive(1'b1, mword(1'b0), 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4));
    rst_n      = 1'b0;
    data_valid = 1'b1;
    data       = 16'($urandom);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({locked, lock_event, unlock_event, marker_phase, frame_start, err_cnt} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid_acquire_outputs: got %b, expected all zero",
               {locked, lock_event, unlock_event, marker_phase, frame_start, err_cnt});
    end
    rst_n      = 1'b1;
    cur_locked = 1'b0;
    cur_err    = 8'd0;
    acquire(1'b0, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    data_valid = 1'b0;
    resync_n   = 1'b1;
    data       = 16'h0000;
    cur_locked = 1'b0;
    cur_err    = 8'd0;
    cur_ph     = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_lock();
    test_gaps();
    test_acq_restart();
    test_loss();
    test_resync();
    test_resync_collision();
    test_reset_mid_acquire();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dop_lock_monitor.md
Name: dop_lock_monitor

Overview:
Parametrised successor to the DoP detector. Watches the PCM word stream from the FX2LP FIFO and finds DoP marker framing across N interleaved channels and a configurable number of words per sample. Acquires lock with a frame count, keeps lock with loss hysteresis and a flywheel marker phase, and drops lock on its own. Sits beside the PCM/DSD mode mux; `locked` selects the DSD path.

Parameters:
DATA_W, 16, FIFO word width (>= 8)
CHANNELS, 2, interleaved channels per frame (1..8)
WORDS_PER_SAMPLE, 2, words per channel sample; word 0 carries the marker
MARKER_0, 8'h05, first DoP marker
MARKER_1, 8'hFA, second DoP marker
ACQ_COUNT, 16, consecutive good frames needed to lock (>= 1)
LOSS_COUNT, 4, consecutive bad frames needed to drop lock (>= 1)
CNT_W, 5, width of the acquire and loss counters; must hold max(ACQ_COUNT, LOSS_COUNT)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
data  in  DATA_W  stream word; the marker is data[DATA_W-1 -: 8]
data_valid  in  1  word qualifier; one word per cycle when high
resync_n  in  1  synchronous active-low forced re-hunt
locked  out  1  DoP lock status
lock_event  out  1  one-cycle pulse on the rise of locked
unlock_event  out  1  one-cycle pulse on the fall of locked
marker_phase  out  1  expected marker of the current frame (0 = MARKER_0, 1 = MARKER_1)
frame_start  out  1  pulse the cycle after the first word of a frame is accepted while locked
err_cnt  out  8  saturating count of bad frames since the last lock

Behaviour:
- Reset: one clock, synchronous, active-low (rst_n sampled on rising clk). All outputs and all internal counters go to 0. State goes to HUNT.
- Frame definition:
  - A frame is CHANNELS*WORDS_PER_SAMPLE valid words.
  - The marker word is word index 0 of each sample.
  - Every marker word in a frame must equal the frame marker.
  - The frame marker alternates MARKER_0/MARKER_1 from frame to frame.
  - Cycles with data_valid=0 are ignored entirely; no counter moves.
- Counters: word index (0..WPS-1) and channel index (0..CHANNELS-1) wrap together on valid words only. Wrap of the last word of the last channel ends the frame.
- States:
  - HUNT: a valid word whose marker byte equals MARKER_0 or MARKER_1 sets word=0, ch=0 and phase = the matched marker. Word counter advances and the state moves to ACQUIRE. Other words are discarded. Either marker may start acquisition.
  - ACQUIRE: checks each marker word against phase. On mismatch: counters clear, acq_cnt clears, and the same word is re-evaluated as a HUNT candidate in the same cycle, so it can restart ACQUIRE immediately. At each good frame end, acq_cnt increments and phase toggles. When acq_cnt reaches ACQ_COUNT the state becomes LOCKED: locked=1 and lock_event=1 in the following cycle, err_cnt clears to 0, acq_cnt clears.
  - LOCKED: counters and phase run as a flywheel; there is no realignment. A frame is bad if any of its marker words mismatched (sticky flag per frame).
    - Good frame end: loss_cnt clears.
    - Bad frame end: loss_cnt and err_cnt (saturating at 255) increment.
    - loss_cnt reaching LOSS_COUNT: state goes to HUNT, locked=0, unlock_event=1 the next cycle, counters clear. err_cnt holds its value.
- resync_n=0: takes priority over data_valid and all transitions. Next cycle: state is HUNT, all counters clear, locked=0. unlock_event pulses only if locked was 1. err_cnt holds.
- Simultaneous events: a lock-completing frame end with resync_n=0 ends in HUNT with no lock_event. Reset beats everything.
- frame_start and both event pulses are registered and last exactly one cycle. marker_phase is valid only while locked=1; it reads 0 otherwise.
- Latency: data word to locked or unlock_event is one cycle after the deciding word.

Decomposition:
- Package dop_pkg holds:
  - DOP_MARKER_0/1 constants
  - state enum HUNT/ACQUIRE/LOCKED
  - marker-byte extract helper
- One sub-module, dop_frame_counter: valid-gated word/channel counters with clear input, sync-load-to-zero and frame_end output.

Test Plan:
All scenarios use defaults (CH=2, WPS=2, 4 words per frame, ACQ=16, LOSS=4).
1. Clean DoP starting at 05 for 64 words, valid every cycle -> locked=0 through word 63; locked=1 and lock_event=1 the cycle after word 64; marker_phase toggles every 4 words.
2. Clean stream starting at FA phase, random valid gaps of 0-3 cycles -> lock after exactly 16 frames of valid words; no counter advance during gaps.
3. Marker at word 40 (ACQUIRE) corrupted to FA where 05 was expected -> acq_cnt=0; that word restarts ACQUIRE with phase=FA; lock arrives 64 valid words later.
4. Locked, then 3 bad frames followed by a good one -> locked stays 1 and err_cnt=3. Then 4 consecutive bad frames -> unlock_event one cycle after the last word of the 4th bad frame, err_cnt=7.
5. Locked, resync_n low for 1 cycle during valid data -> locked=0 and unlock_event next cycle; HUNT; re-lock after 16 more good frames with err_cnt=0.
6. rst_n low mid-ACQUIRE at frame 10 -> all outputs 0 next cycle; the next lock needs a full 16 frames.
